// File: rtl/reg_sync_hs.sv
// ---------------------------------------------------------------------------
// reg_sync_hs
//
// Pipeline register stage with a valid/ready handshake on both sides and a
// two-entry skid buffer. The stage decides capture itself from the handshake,
// back-pressures the upstream producer and breaks the ready path, while still
// sustaining one transfer per cycle.
//
// Handshake: a word moves on the slave side when i_s_valid & o_s_ready, and on
// the master side when o_m_valid & i_m_ready, both sampled at the rising edge.
// A producer keeps i_s_valid/i_s_data stable until it is accepted. Once
// o_m_valid is high it stays high with o_m_data stable until accepted, unless
// a flush or reset intervenes.
//
// Parameters:
//   DATA_WIDTH  payload width in bits
//   RSTN_VALUE  value loaded into the main and skid registers on reset
//
// Ports:
//   i_clk      clock, all state updates on the rising edge
//   i_rst_n    synchronous active-low reset
//   i_flush    synchronous flush, drops all held entries (data regs keep value)
//   i_s_valid  upstream data valid
//   o_s_ready  stage can accept (flop output)
//   i_s_data   upstream payload
//   o_m_valid  downstream data valid (flop output)
//   i_m_ready  downstream can accept
//   o_m_data   downstream payload, the main register
// ---------------------------------------------------------------------------
module reg_sync_hs #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RSTN_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data
);

  // 2'b11 is unused and recovers to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,  // nothing held
    ST_BUSY  = 2'b01,  // main held, skid empty
    ST_FULL  = 2'b10   // main and skid held
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic                  m_valid_q;
  logic                  s_ready_q;
  logic                  m_valid_d;
  logic                  s_ready_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

  logic                  s_fire;
  logic                  m_fire;
  logic                  load_main;
  logic                  main_from_skid;
  logic                  load_skid;

  assign s_fire    = i_s_valid & s_ready_q;
  assign m_fire    = m_valid_q & i_m_ready;

  assign o_s_ready = s_ready_q;
  assign o_m_valid = m_valid_q;
  assign o_m_data  = main_q;

  // State register. The handshake outputs are registered alongside the state
  // (computed from the next state) so they leave the block straight from flops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_EMPTY;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
    end
  end

  // Next-state and data-load decisions. Flush wins over any handshake in the
  // same cycle, so neither a capture nor a skid-to-main move happens then.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (s_fire) begin
            load_main = 1'b1;
            state_d   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          case ({s_fire, m_fire})
            2'b11: load_main = 1'b1;
            2'b10: begin
              load_skid = 1'b1;
              state_d   = ST_FULL;
            end
            2'b01: state_d = ST_EMPTY;
            default: state_d = ST_BUSY;
          endcase
        end
        ST_FULL: begin
          // o_s_ready is low here, so only the downstream side can move.
          if (m_fire) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output decode of the next state, registered in the state register above.
  always_comb begin
    m_valid_d = 1'b0;
    s_ready_d = 1'b1;
    case (state_d)
      ST_EMPTY: begin
        m_valid_d = 1'b0;
        s_ready_d = 1'b1;
      end
      ST_BUSY: begin
        m_valid_d = 1'b1;
        s_ready_d = 1'b1;
      end
      ST_FULL: begin
        m_valid_d = 1'b1;
        s_ready_d = 1'b0;
      end
      default: begin
        m_valid_d = 1'b0;
        s_ready_d = 1'b1;
      end
    endcase
  end

  // Data registers load only on the handshake transitions; flush leaves them.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      main_q <= RSTN_VALUE;
      skid_q <= RSTN_VALUE;
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : i_s_data;
      end
      if (load_skid) begin
        skid_q <= i_s_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_sync_hs.sv
module tb_reg_sync_hs;

  localparam int          W    = 32;
  localparam logic [W-1:0] RSTV = 32'hDEAD_BEEF;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;

  always #5 clk = ~clk;

  reg_sync_hs #(
    .DATA_WIDTH (W),
    .RSTN_VALUE (RSTV)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush   (flush),
    .i_s_valid (s_valid),
    .o_s_ready (s_ready),
    .i_s_data  (s_data),
    .o_m_valid (m_valid),
    .i_m_ready (m_ready),
    .o_m_data  (m_data)
  );

  // ---------------- counters ----------------
  int compared   = 0;
  int mismatched = 0;

  // ---------------- reference model ----------------
  // exp_q holds the words the stage owes downstream, oldest first (at most 2).
  // shown is the word the output register presents (last head of the queue).
  logic [W-1:0] exp_q[$];
  logic [W-1:0] shown;
  int           delivered;

  // Driver: apply inputs for one cycle (called just after a falling edge),
  // update the model at the rising edge, return at the next falling edge.
  task automatic step(input logic rst_i, input logic v, input logic [W-1:0] d,
                      input logic mr, input logic fl);
    logic sf;
    logic mf;
    rst_n   = rst_i;
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
    @(posedge clk);
    if (!rst_i) begin
      exp_q.delete();
      shown = RSTV;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      sf = v && (exp_q.size() < 2);
      mf = (exp_q.size() > 0) && mr;
      if (mf) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (sf) exp_q.push_back(d);
      if (exp_q.size() > 0) shown = exp_q[0];
    end
    @(negedge clk);
  endtask

  // ---------------- protocol monitor ----------------
  // A presented word must stay presented and unchanged until taken, unless
  // flush or reset intervened at that edge.
  logic         armed = 1'b0;
  logic         p_valid, p_mready, p_flush, p_rst;
  logic [W-1:0] p_data;

  always @(posedge clk) begin
    p_valid  <= m_valid;
    p_data   <= m_data;
    p_mready <= m_ready;
    p_flush  <= flush;
    p_rst    <= rst_n;
    armed    <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed && p_valid && !p_mready && !p_flush && p_rst) begin
      compared++;
      if (m_valid !== 1'b1 || m_data !== p_data) begin
        mismatched++;
        $display("FAIL proto_hold: valid=%b data=%h required valid=1 data=%h",
                 m_valid, m_data, p_data);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL reset: valid=%b ready=%b data=%h required 0 1 deadbeef",
               m_valid, s_ready, m_data);
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL reset_release: valid=%b ready=%b data=%h required 0 1 deadbeef",
               m_valid, s_ready, m_data);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, W'(i), 1'b1, 1'b0);
      compared++;
      if (m_valid !== 1'b1 || s_ready !== 1'b1 || m_data !== W'(i)) begin
        mismatched++;
        $display("FAIL stream_%0d: valid=%b ready=%b data=%h required 1 1 %h",
                 i, m_valid, s_ready, m_data, W'(i));
      end
    end
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'h8) begin
      mismatched++;
      $display("FAIL stream_drain: valid=%b ready=%b data=%h required 0 1 8",
               m_valid, s_ready, m_data);
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
    compared++;
    if (m_valid !== 1'b1 || s_ready !== 1'b1 || m_data !== 32'hA) begin
      mismatched++;
      $display("FAIL stall_a: valid=%b ready=%b data=%h required 1 1 a",
               m_valid, s_ready, m_data);
    end
    step(1'b1, 1'b1, 32'hB, 1'b0, 1'b0);
    compared++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== 32'hA) begin
      mismatched++;
      $display("FAIL stall_b: valid=%b ready=%b data=%h required 1 0 a",
               m_valid, s_ready, m_data);
    end
    step(1'b1, 1'b1, 32'hC, 1'b0, 1'b0);
    compared++;
    if (s_ready !== 1'b0 || m_data !== 32'hA) begin
      mismatched++;
      $display("FAIL stall_c_held: ready=%b data=%h required 0 a", s_ready, m_data);
    end
    // Release: A leaves, B moves up, ready returns; C not yet accepted.
    step(1'b1, 1'b1, 32'hC, 1'b1, 1'b0);
    compared++;
    if (m_valid !== 1'b1 || s_ready !== 1'b1 || m_data !== 32'hB) begin
      mismatched++;
      $display("FAIL stall_rel_b: valid=%b ready=%b data=%h required 1 1 b",
               m_valid, s_ready, m_data);
    end
    step(1'b1, 1'b1, 32'hC, 1'b1, 1'b0);
    compared++;
    if (m_valid !== 1'b1 || m_data !== 32'hC) begin
      mismatched++;
      $display("FAIL stall_rel_c: valid=%b data=%h required 1 c", m_valid, m_data);
    end
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_empty: valid=%b ready=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_flush_full();
    step(1'b1, 1'b1, 32'h31, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h32, 1'b0, 1'b0);
    compared++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h31) begin
      mismatched++;
      $display("FAIL flush_fill: valid=%b ready=%b data=%h required 1 0 31",
               m_valid, s_ready, m_data);
    end
    step(1'b1, 1'b1, 32'h33, 1'b1, 1'b1);
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'h31) begin
      mismatched++;
      $display("FAIL flush: valid=%b ready=%b data=%h required 0 1 31",
               m_valid, s_ready, m_data);
    end
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_after: valid=%b ready=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_random();
    logic         v = 1'b0;
    logic [W-1:0] d = '0;
    logic         mr;
    logic         took = 1'b1;
    int           start = delivered;
    for (int c = 0; c < 10000; c++) begin
      // A pending word stays put until the stage takes it.
      if (!(v && !took)) begin
        v = 1'($urandom_range(0, 1));
        d = $urandom;
      end
      mr   = 1'($urandom_range(0, 1));
      took = (exp_q.size() < 2);
      step(1'b1, v, d, mr, 1'b0);
      compared++;
      if (m_valid !== (exp_q.size() > 0) || s_ready !== (exp_q.size() < 2) ||
          m_data !== shown) begin
        mismatched++;
        $display("FAIL random_c%0d: valid=%b ready=%b data=%h required %b %b %h",
                 c, m_valid, s_ready, m_data, exp_q.size() > 0, exp_q.size() < 2, shown);
      end
    end
    compared++;
    if (delivered - start < 1000) begin
      mismatched++;
      $display("FAIL random_volume: delivered=%0d required at least 1000",
               delivered - start);
    end
    // Drain what is left.
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_full();
    step(1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
    compared++;
    if (s_ready !== 1'b0 || m_data !== 32'h11) begin
      mismatched++;
      $display("FAIL rst_full_fill: ready=%b data=%h required 0 11", s_ready, m_data);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL rst_full: valid=%b ready=%b data=%h required 0 1 deadbeef",
               m_valid, s_ready, m_data);
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      compared++;
      if (m_valid !== 1'b0 || m_data === 32'h11 || m_data === 32'h22) begin
        mismatched++;
        $display("FAIL rst_full_leak_%0d: valid=%b data=%h required 0 and not 11/22",
                 c, m_valid, m_data);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    shown     = RSTV;
    delivered = 0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_stall();
    test_flush_full();
    test_random();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
